// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads instruction memory at the current PC, hands the word
// to the decoder, then steps the PC by increment or branch.
module fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_enable,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_value,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [1:0]         state_dbg
);

  // Handshakes: a memory read completes on an edge where mem_req and mem_ready are both 1;
  // an instruction is consumed on an edge where instr_valid and instr_ack are both 1.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ADV   = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e state;
  logic   branch_flag;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FETCH;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      instr         <= '0;
      instr_valid   <= 1'b0;
      pc_enable     <= 1'b0;
      pc_load       <= 1'b0;
      pc_load_value <= '0;
      branch_flag   <= 1'b0;
    end else begin
      pc_enable <= 1'b0;
      pc_load   <= 1'b0;
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc_value;
          end else if (mem_ready) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            branch_flag <= branch_req;
            if (branch_req) pc_load_value <= branch_target;
            pc_enable   <= !branch_req;
            pc_load     <= branch_req;
            state       <= ADV;
          end
        end
        ADV: begin
          if (halt) begin
            state <= STOP;
          end else begin
            // pc updates on this same edge, so request the address it is about to hold.
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= branch_flag ? pc_load_value : pc_value + ADDR_W'(1);
          end
        end
        STOP: begin
          if (!halt) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_addr <= pc_value;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
